// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter that shares one framebuffer write port between N_CAM pixel requesters.
// Optional drop counter for out-of-range pixels is enabled by defining FB_ARB_DROP_CNT_EN.
module fb_write_arbiter #(
  parameter int N_CAM  = 4,
  parameter int FB_W   = 640,
  parameter int FB_H   = 480,
  parameter int ADDR_W = 19
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic [N_CAM-1:0]    cam_en,
  input  logic [N_CAM-1:0]    req_valid,
  output logic [N_CAM-1:0]    req_ready,
  input  logic [N_CAM*12-1:0] req_x,
  input  logic [N_CAM*11-1:0] req_y,
  input  logic [N_CAM*8-1:0]  req_pixel,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [7:0]          wr_data,
  output logic [2:0]          wr_src
`ifdef FB_ARB_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt,
  input  logic                drop_clr
`endif
);

  localparam int PW     = (N_CAM > 1) ? $clog2(N_CAM) : 1;
  localparam int CW     = $clog2(FB_W);
  localparam int PROD_W = 11 + CW;
  localparam logic [11:0] X_LIM = 12'(FB_W);
  localparam logic [10:0] Y_LIM = 11'(FB_H);

  // y*FB_W is formed at full width before the add, then truncated to the port width
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [10:0] y, input logic [11:0] x);
    logic [PROD_W-1:0] prod;
    logic [PROD_W:0]   sum;
    prod = PROD_W'(y) * PROD_W'(FB_W);
    sum  = {1'b0, prod} + (PROD_W+1)'(x);
    return ADDR_W'(sum);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [PW-1:0]     r_rr_ptr;
  logic              r_wr_en_p1;
  logic [ADDR_W-1:0] r_wr_addr_p1;
  logic [7:0]        r_wr_data_p1;
  logic [2:0]        r_wr_src_p1;

  logic [N_CAM-1:0]  w_elig;
  logic              w_gnt_vld;
  logic [PW-1:0]     w_gnt;
  logic [PW-1:0]     w_rr_next;
  logic              w_free;
  logic              w_accept;
  logic [N_CAM-1:0]  w_rdy;
  logic [11:0]       w_sel_x;
  logic [10:0]       w_sel_y;
  logic [7:0]        w_sel_pix;
  logic              w_in_range;

  assign w_elig = req_valid & cam_en;
  assign w_free = ~r_wr_en_p1 | wr_ready;

  always_comb begin
    logic [PW:0] v_idx;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    v_idx     = '0;
    for (int k = 0; k < N_CAM; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (v_idx >= (PW+1)'(N_CAM)) v_idx = v_idx - (PW+1)'(N_CAM);
      if (!w_gnt_vld && w_elig[v_idx[PW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = v_idx[PW-1:0];
      end
    end
  end

  // No handshake completes while reset is asserted
  assign w_accept = w_gnt_vld & w_free & rst_n;

  always_comb begin
    w_rdy = '0;
    if (w_accept) w_rdy[w_gnt] = 1'b1;
  end

  assign req_ready  = w_rdy;
  assign w_rr_next  = (w_gnt == PW'(N_CAM - 1)) ? '0 : w_gnt + PW'(1);
  assign w_sel_x    = req_x[int'(w_gnt)*12 +: 12];
  assign w_sel_y    = req_y[int'(w_gnt)*11 +: 11];
  assign w_sel_pix  = req_pixel[int'(w_gnt)*8 +: 8];
  assign w_in_range = (w_sel_x < X_LIM) && (w_sel_y < Y_LIM);

  // Stage p0 -> p1: registered write port; holds every field while the framebuffer stalls
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
      r_wr_src_p1  <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_rr_next;
      if (w_in_range) begin
        r_wr_en_p1   <= 1'b1;
        r_wr_addr_p1 <= lin_addr(w_sel_y, w_sel_x);
        r_wr_data_p1 <= w_sel_pix;
        r_wr_src_p1  <= 3'(w_gnt);
      end else begin
        r_wr_en_p1   <= 1'b0;
      end
    end else if (wr_ready) begin
      r_wr_en_p1 <= 1'b0;
    end
  end

  assign wr_en   = r_wr_en_p1;
  assign wr_addr = r_wr_addr_p1;
  assign wr_data = r_wr_data_p1;
  assign wr_src  = r_wr_src_p1;

`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (drop_clr) begin
      r_drop_cnt <= '0;
    end else if (w_accept && !w_in_range) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: vector table for arbitration order plus hand-written
// sequences for bounds, backpressure, drop counting and mid-stream reset.
module tb_fb_write_arbiter;

  logic        pclk;
  logic        rst_n;
  logic [3:0]  cam_en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_x;
  logic [43:0] req_y;
  logic [31:0] req_pixel;
  logic        wr_en;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  wr_src;
`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic        drop_clr;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fb_write_arbiter #(.N_CAM(4), .FB_W(640), .FB_H(480), .ADDR_W(19)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .cam_en    (cam_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_pixel (req_pixel),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
`ifdef FB_ARB_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt),
    .drop_clr  (drop_clr)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [3:0]  cam;
    logic [3:0]  vld;
    logic        wrdy;
    logic [3:0]  e_rdy;
    logic        e_en;
    logic [2:0]  e_src;
    logic [18:0] e_addr;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [11:0] x, input logic [10:0] y,
                         input logic [7:0] p);
    req_x[12*i +: 12]   = x;
    req_y[11*i +: 11]   = y;
    req_pixel[8*i +: 8] = p;
  endtask

  // Called just after a negedge with inputs already driven
  task automatic run_cycle(input string nm, input logic [3:0] e_rdy, input logic e_en,
                           input logic [18:0] e_addr, input logic [7:0] e_data,
                           input logic [2:0] e_src);
    #1;
    chk({nm, "_rdy"}, 32'(req_ready), 32'(e_rdy));
    @(posedge pclk);
    #1;
    chk({nm, "_en"}, 32'(wr_en), 32'(e_en));
    if (e_en) begin
      chk({nm, "_addr"}, 32'(wr_addr), 32'(e_addr));
      chk({nm, "_data"}, 32'(wr_data), 32'(e_data));
      chk({nm, "_src"},  32'(wr_src),  32'(e_src));
    end
    @(negedge pclk);
  endtask

  initial begin
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 3'd0, 19'd0, 8'h10};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 3'd1, 19'd1, 8'h11};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 3'd2, 19'd2, 8'h12};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 3'd3, 19'd3, 8'h13};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 3'd0, 19'd0, 8'h10};
    tbl[5]  = '{4'hB, 4'hF, 1'b1, 4'b0010, 1'b1, 3'd1, 19'd1, 8'h11};
    tbl[6]  = '{4'hB, 4'hF, 1'b1, 4'b1000, 1'b1, 3'd3, 19'd3, 8'h13};
    tbl[7]  = '{4'hB, 4'hF, 1'b1, 4'b0001, 1'b1, 3'd0, 19'd0, 8'h10};
    tbl[8]  = '{4'hB, 4'hF, 1'b1, 4'b0010, 1'b1, 3'd1, 19'd1, 8'h11};
    tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 3'd2, 19'd2, 8'h12};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 3'd3, 19'd3, 8'h13};
    tbl[11] = '{4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 3'd0, 19'd0, 8'h00};

    rst_n     = 1'b0;
    cam_en    = 4'h0;
    req_valid = 4'h0;
    wr_ready  = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_pixel = '0;
`ifdef FB_ARB_DROP_CNT_EN
    drop_clr  = 1'b0;
`endif
    for (int i = 0; i < 4; i++) set_req(i, 12'(i), 11'd0, 8'h10 + 8'(i));

    @(negedge pclk);
    @(negedge pclk);
    #2;
    chk("rst_en",   32'(wr_en),     0);
    chk("rst_addr", 32'(wr_addr),   0);
    chk("rst_data", 32'(wr_data),   0);
    chk("rst_src",  32'(wr_src),    0);
    chk("rst_rdy",  32'(req_ready), 0);
`ifdef FB_ARB_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt),  0);
`endif
    @(negedge pclk);
    rst_n = 1'b1;

    // Round robin over all requesters, then with requester 2 masked off
    for (int r = 0; r < 12; r++) begin
      cam_en    = tbl[r].cam;
      req_valid = tbl[r].vld;
      wr_ready  = tbl[r].wrdy;
      run_cycle($sformatf("tbl%0d", r), tbl[r].e_rdy, tbl[r].e_en, tbl[r].e_addr,
                tbl[r].e_data, tbl[r].e_src);
    end

    // Far corner pixel from requester 2 alone (pointer is at 0)
    set_req(2, 12'd639, 11'd479, 8'hA5);
    req_valid = 4'b0100;
    run_cycle("corner", 4'b0100, 1'b1, 19'd307199, 8'hA5, 3'd2);
    set_req(2, 12'd2, 11'd0, 8'h12);

    // Out-of-range x from requester 1: consumed, dropped, pointer moves to 2
    set_req(1, 12'd640, 11'd0, 8'h77);
    req_valid = 4'b0010;
    run_cycle("oob", 4'b0010, 1'b0, 19'd0, 8'h00, 3'd0);
`ifdef FB_ARB_DROP_CNT_EN
    chk("drop_one", 32'(drop_cnt), 1);
`endif
    set_req(1, 12'd1, 11'd0, 8'h11);
    req_valid = 4'hF;
    run_cycle("oob_next", 4'b0100, 1'b1, 19'd2, 8'h12, 3'd2);

    // Backpressure with output full: nothing granted, fields frozen
    wr_ready = 1'b0;
    for (int c = 0; c < 5; c++)
      run_cycle($sformatf("bp%0d", c), 4'b0000, 1'b1, 19'd2, 8'h12, 3'd2);
    wr_ready = 1'b1;
`ifdef FB_ARB_DROP_CNT_EN
    drop_clr = 1'b1;
`endif
    run_cycle("bp_rel0", 4'b1000, 1'b1, 19'd3, 8'h13, 3'd3);
`ifdef FB_ARB_DROP_CNT_EN
    chk("drop_clr", 32'(drop_cnt), 0);
    drop_clr = 1'b0;
`endif
    run_cycle("bp_rel1", 4'b0001, 1'b1, 19'd0, 8'h10, 3'd0);

    // Reset while a write is in flight
    chk("pre_rst_en", 32'(wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk("async_en",   32'(wr_en),     0);
    chk("async_addr", 32'(wr_addr),   0);
    chk("async_rdy",  32'(req_ready), 0);
    @(negedge pclk);
    rst_n  = 1'b1;
    cam_en = 4'b1110;
    run_cycle("post_rst", 4'b0010, 1'b1, 19'd1, 8'h11, 3'd1);
    cam_en = 4'hF;
    run_cycle("post_rst2", 4'b0100, 1'b1, 19'd2, 8'h12, 3'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
